imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_if.sv | 23 ++
 rtl/imem_loader.sv | 170 +++++++++++++++++
 tb/tb_imem_loader.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the imem loader.
// master = loader side, slave = stream source / memory side.
interface imem_loader_if;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;

  logic              byte_valid;
  logic [BYTE_W-1:0] byte_data;
  logic              byte_ready;
  logic              we;
  logic [WORD_W-1:0] waddr;
  logic [WORD_W-1:0] wdata;

  modport master (
    input  byte_valid, byte_data,
    output byte_ready, we, waddr, wdata
  );

  modport slave (
    output byte_valid, byte_data,
    input  byte_ready, we, waddr, wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Streams a length-prefixed little-endian program image into instruction memory.
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  imem_loader_if.master bus,
  output logic          cpu_reset,
  output logic          busy,
  output logic          done,
  output logic          error
);
  localparam int unsigned LEN_W  = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE, LEN_LO, LEN_HI, DATA, WRITE, CHECK, DONE, ERR
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR
  } state_t;
`endif

  state_t            state;
  logic [LEN_W-1:0]  n_words;
  logic [LEN_W-1:0]  index;
  logic [1:0]        byte_cnt;
  logic [23:0]       shift;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] csum;
`endif

  logic              xfer;
  logic [LEN_W-1:0]  len_full;
  logic              len_bad;
  logic              last_word;

  assign xfer      = bus.byte_valid & bus.byte_ready;
  assign len_full  = {bus.byte_data, n_words[7:0]};
  assign len_bad   = (len_full == '0) || (WORD_W'(len_full) > DEPTH);
  assign last_word = (index == (n_words - LEN_W'(1)));

  // Session FSM; every output is updated together with the state it belongs to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      n_words        <= '0;
      index          <= '0;
      byte_cnt       <= '0;
      shift          <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum           <= '0;
`endif
      bus.byte_ready <= 1'b0;
      bus.we         <= 1'b0;
      bus.waddr      <= '0;
      bus.wdata      <= '0;
      cpu_reset      <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
    end else begin
      bus.we <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state          <= LEN_LO;
            n_words        <= '0;
            index          <= '0;
            byte_cnt       <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum           <= '0;
`endif
            bus.byte_ready <= 1'b1;
            cpu_reset      <= 1'b1;
            busy           <= 1'b1;
            done           <= 1'b0;
            error          <= 1'b0;
          end
        end

        LEN_LO: begin
          if (xfer) begin
            n_words[7:0] <= bus.byte_data;
            state        <= LEN_HI;
          end
        end

        LEN_HI: begin
          if (xfer) begin
            if (len_bad) begin
              state          <= ERR;
              bus.byte_ready <= 1'b0;
              busy           <= 1'b0;
              error          <= 1'b1;
            end else begin
              n_words[15:8] <= bus.byte_data;
              state         <= DATA;
            end
          end
        end

        // Bytes shift in from the top so byte 0 ends up in wdata[7:0].
        DATA: begin
          if (xfer) begin
            shift    <= {bus.byte_data, shift[23:8]};
            byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum     <= csum ^ bus.byte_data;
`endif
            if (byte_cnt == 2'd3) begin
              state          <= WRITE;
              bus.byte_ready <= 1'b0;
              bus.we         <= 1'b1;
              bus.wdata      <= {bus.byte_data, shift};
              bus.waddr      <= BASE_ADDR + (WORD_W'(index) << 2);
            end
          end
        end

        WRITE: begin
          if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state          <= CHECK;
            bus.byte_ready <= 1'b1;
`else
            state          <= DONE;
            busy           <= 1'b0;
            done           <= 1'b1;
            cpu_reset      <= 1'b0;
`endif
          end else begin
            index          <= index + LEN_W'(1);
            state          <= DATA;
            bus.byte_ready <= 1'b1;
          end
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        CHECK: begin
          if (xfer) begin
            bus.byte_ready <= 1'b0;
            busy           <= 1'b0;
            if (bus.byte_data == csum) begin
              state     <= DONE;
              done      <= 1'b1;
              cpu_reset <= 1'b0;
            end else begin
              state     <= ERR;
              error     <= 1'b1;
            end
          end
        end
`endif

        default: begin
          state          <= IDLE;
          bus.byte_ready <= 1'b0;
          busy           <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: session-level reference model plus a per-cycle write checker.
module tb_imem_loader;
  localparam int unsigned DEPTH     = 1024;
  localparam logic [31:0] BASE_ADDR = 32'h0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic cpu_reset, busy, done, error;

  imem_loader_if bus();

  imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bus       (bus),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  wr_t         exp_q[$];
  wr_t         cap_q[$];
  logic [31:0] last_addr = '0;
  logic [31:0] last_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  // Every cycle: a write must match the next modelled word; otherwise the bus must hold.
  always @(negedge clk) begin
    if (bus.we === 1'b1) begin
      wr_t e;
      chk("byte_ready_low_in_write", 32'(bus.byte_ready), 32'd0);
      cap_q.push_back({bus.waddr, bus.wdata});
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_we: addr 0x%08h data 0x%08h, required no write", bus.waddr, bus.wdata);
      end else begin
        e = exp_q.pop_front();
        chk("waddr", bus.waddr, e.addr);
        chk("wdata", bus.wdata, e.data);
        last_addr = e.addr;
        last_data = e.data;
      end
    end else begin
      chk("waddr_hold", bus.waddr, last_addr);
      chk("wdata_hold", bus.wdata, last_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit acc = 1'b0;
    int budget = 0;
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    while (!acc) begin
      @(negedge clk);
      acc = (bus.byte_ready === 1'b1);
      tick();
      budget++;
      if (!acc && budget > 50) begin
        n_checks++;
        n_fail++;
        $display("FAIL byte_accept_timeout: byte 0x%02h not accepted in %0d cycles, required acceptance", b, budget);
        break;
      end
    end
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'($urandom);
    if (gap) tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy",      32'(busy),           32'd1);
    chk("start_done_clr",  32'(done),           32'd0);
    chk("start_err_clr",   32'(error),          32'd0);
    chk("start_cpu_reset", 32'(cpu_reset),      32'd1);
    chk("start_ready",     32'(bus.byte_ready), 32'd1);
  endtask

  task automatic wait_idle();
    int budget = 0;
    while (busy !== 1'b0) begin
      @(negedge clk);
      budget++;
      if (budget > 20) begin
        n_checks++;
        n_fail++;
        $display("FAIL session_end_timeout: busy=%0b after %0d cycles, required 0", busy, budget);
        break;
      end
    end
    tick();
  endtask

  // Reference model: derive writes and outcome from the stream, then drive it.
  task automatic run_session(input logic [7:0] s_in[$], input bit gap, input bit start_mid);
    logic [7:0]  s[$];
    int unsigned n;
    int          consumed;
    logic [7:0]  x;
    bit          exp_ok;
    wr_t         e;
    s = s_in;
    n = {16'd0, s[1], s[0]};
    if (n == 0 || n > DEPTH) begin
      exp_ok   = 1'b0;
      consumed = 2;
    end else begin
      consumed = 2 + 4 * int'(n);
      x = 8'h00;
      for (int w = 0; w < int'(n); w++) begin
        e.addr = BASE_ADDR + 32'(w) * 32'd4;
        e.data = {s[5 + 4*w], s[4 + 4*w], s[3 + 4*w], s[2 + 4*w]};
        exp_q.push_back(e);
      end
      for (int i = 2; i < consumed; i++) x = x ^ s[i];
      exp_ok = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (s.size() == consumed) s.push_back(x);
      exp_ok = (s[consumed] == x);
`endif
    end

    pulse_start();
    for (int i = 0; i < s.size(); i++) begin
      send_byte(s[i], gap);
      if (start_mid && i == 4) begin
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("mid_start_busy", 32'(busy), 32'd1);
        chk("mid_start_done", 32'(done), 32'd0);
      end
    end
    wait_idle();
    chk("sess_done",      32'(done),      32'(exp_ok));
    chk("sess_error",     32'(error),     32'(!exp_ok));
    chk("sess_cpu_reset", 32'(cpu_reset), 32'(!exp_ok));
    chk("sess_all_written", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v[$];
    reset          = 1'b0;
    start          = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    repeat (3) tick();
    chk("rst_we",        32'(bus.we),         32'd0);
    chk("rst_waddr",     bus.waddr,           32'd0);
    chk("rst_wdata",     bus.wdata,           32'd0);
    chk("rst_ready",     32'(bus.byte_ready), 32'd0);
    chk("rst_busy",      32'(busy),           32'd0);
    chk("rst_done",      32'(done),           32'd0);
    chk("rst_error",     32'(error),          32'd0);
    chk("rst_cpu_reset", 32'(cpu_reset),      32'd1);
    reset = 1'b1;
    repeat (2) tick();
    chk("idle_cpu_reset_held", 32'(cpu_reset), 32'd1);

    // Basic two-word load, literal expectations pin the model.
    v = '{8'h02, 8'h00, 8'h13, 8'h01, 8'h50, 8'h00, 8'h93, 8'h01, 8'hC0, 8'h00};
    cap_q.delete();
    run_session(v, 1'b0, 1'b0);
    chk("basic_count", 32'(cap_q.size()), 32'd2);
    if (cap_q.size() == 2) begin
      chk("basic_addr0", cap_q[0].addr, 32'h0);
      chk("basic_data0", cap_q[0].data, 32'h0050_0113);
      chk("basic_addr1", cap_q[1].addr, 32'h4);
      chk("basic_data1", cap_q[1].data, 32'h00C0_0193);
    end
    chk("basic_done",      32'(done),      32'd1);
    chk("basic_cpu_reset", 32'(cpu_reset), 32'd0);
    chk("basic_error",     32'(error),     32'd0);

    // Bad lengths: zero and DEPTH+1.
    cap_q.delete();
    v = '{8'h00, 8'h00};
    run_session(v, 1'b0, 1'b0);
    chk("len0_error",     32'(error),     32'd1);
    chk("len0_cpu_reset", 32'(cpu_reset), 32'd1);
    v = '{8'h01, 8'h04};
    run_session(v, 1'b0, 1'b0);
    chk("len1025_error",     32'(error),     32'd1);
    chk("len1025_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("badlen_no_we",      32'(cap_q.size()), 32'd0);

    // Backpressure: idle cycle after every byte.
    v = '{8'h02, 8'h00, 8'h13, 8'h01, 8'h50, 8'h00, 8'h93, 8'h01, 8'hC0, 8'h00};
    cap_q.delete();
    run_session(v, 1'b1, 1'b0);
    if (cap_q.size() == 2) begin
      chk("bp_data0", cap_q[0].data, 32'h0050_0113);
      chk("bp_data1", cap_q[1].data, 32'h00C0_0193);
    end else begin
      chk("bp_count", 32'(cap_q.size()), 32'd2);
    end

    // Reset after two data bytes of the first word.
    cap_q.delete();
    pulse_start();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    reset = 1'b0;
    exp_q.delete();
    last_addr = '0;
    last_data = '0;
    #1;
    chk("mid_rst_we",        32'(bus.we),         32'd0);
    chk("mid_rst_waddr",     bus.waddr,           32'd0);
    chk("mid_rst_wdata",     bus.wdata,           32'd0);
    chk("mid_rst_ready",     32'(bus.byte_ready), 32'd0);
    chk("mid_rst_busy",      32'(busy),           32'd0);
    chk("mid_rst_done",      32'(done),           32'd0);
    chk("mid_rst_error",     32'(error),          32'd0);
    chk("mid_rst_cpu_reset", 32'(cpu_reset),      32'd1);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    chk("mid_rst_no_we", 32'(cap_q.size()), 32'd0);
    v = '{8'h02, 8'h00, 8'h13, 8'h01, 8'h50, 8'h00, 8'h93, 8'h01, 8'hC0, 8'h00};
    run_session(v, 1'b0, 1'b0);

    // start in DATA ignored; random three-word image.
    v = '{8'h03, 8'h00};
    for (int i = 0; i < 12; i++) v.push_back(8'($urandom));
    run_session(v, 1'b0, 1'b1);

    // start straight from DONE: single word.
    v = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    cap_q.delete();
    run_session(v, 1'b0, 1'b0);
    if (cap_q.size() == 1) chk("one_word_data", cap_q[0].data, 32'hDEAD_BEEF);
    else chk("one_word_count", 32'(cap_q.size()), 32'd1);

    // Maximum legal length: index must reach DEPTH-1 without wrapping.
    v = '{8'h00, 8'h04};
    for (int i = 0; i < 4 * int'(DEPTH); i++) v.push_back(8'($urandom));
    cap_q.delete();
    run_session(v, 1'b0, 1'b0);
    chk("max_count", 32'(cap_q.size()), DEPTH);
    if (cap_q.size() == DEPTH) chk("max_last_addr", cap_q[DEPTH-1].addr, BASE_ADDR + 32'(4 * (DEPTH - 1)));

`ifdef IMEM_LOADER_CHECKSUM_EN
    v = '{8'h01, 8'h00, 8'h13, 8'h01, 8'h50, 8'h00, 8'h42};
    run_session(v, 1'b0, 1'b0);
    chk("csum_good_done", 32'(done), 32'd1);
    v = '{8'h01, 8'h00, 8'h13, 8'h01, 8'h50, 8'h00, 8'h43};
    run_session(v, 1'b0, 1'b0);
    chk("csum_bad_error",     32'(error),     32'd1);
    chk("csum_bad_cpu_reset", 32'(cpu_reset), 32'd1);
`endif

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
